uart_rx_loader: RTL and testbench

Receive side of the host link: deserialises 8N1 UART bytes from the host and writes them sequentially into the input-image BRAM write port used by the pooling engine. After exactly IMG_BYTES bytes are stored, it pulses start_pooling once and latches load_done. It runs on the divided clock domain, mirroring the transmit path that streams pooled results back to the host.

---
 rtl/uart_rx_loader.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_loader.sv
// rtl/uart_rx_loader.sv - 8N1 UART receiver that streams one image into the pooling input BRAM
// and then kicks off pooling.
module uart_rx_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int IMG_BYTES    = 4096,
  parameter int ADDR_W       = 12
) (
  input  logic              actual_clock,
  input  logic              reset,
  input  logic              rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              start_pooling,
  output logic              load_done,
  output logic              rx_busy,
  output logic              frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] LAST    = (ADDR_W + 1)'(IMG_BYTES - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} r_state_t;
  typedef enum logic [1:0] {L_LOAD, L_START, L_DONE} l_state_t;

  logic rx_meta, rx_s;

  // Both stages reset to idle-high so reset release never looks like a start bit.
  always_ff @(posedge actual_clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  r_state_t      r_state, r_next;
  logic [CW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          byte_valid, byte_valid_n;
  logic          frame_err_n;

  always_ff @(posedge actual_clock or posedge reset) begin
    if (reset) begin
      r_state    <= R_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_state    <= r_next;
      clk_cnt    <= clk_cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    r_next       = r_state;
    clk_cnt_n    = clk_cnt;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    byte_valid_n = 1'b0;
    frame_err_n  = frame_err;
    case (r_state)
      R_IDLE: begin
        if (!rx_s) begin
          r_next    = R_START;
          clk_cnt_n = '0;
        end
      end
      R_START: begin
        if (clk_cnt == HALF_M1) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          r_next    = rx_s ? R_IDLE : R_DATA;
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
      R_DATA: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_n = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) r_next = R_STOP;
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
      R_STOP: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_n = '0;
          if (rx_s) begin
            byte_valid_n = 1'b1;
            r_next       = R_IDLE;
          end else begin
            frame_err_n = 1'b1;
            r_next      = R_WAIT;
          end
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
      // A break holds the line low; wait for idle so it is not taken as a new start.
      R_WAIT: begin
        if (rx_s) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign rx_busy = (r_state == R_START) || (r_state == R_DATA) || (r_state == R_STOP);

  l_state_t          l_state, l_next;
  logic [ADDR_W:0]   cnt, cnt_n;
  logic              wr_en_n, start_pooling_n, load_done_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [7:0]        wr_data_n;

  always_ff @(posedge actual_clock or posedge reset) begin
    if (reset) begin
      l_state       <= L_LOAD;
      cnt           <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      start_pooling <= 1'b0;
      load_done     <= 1'b0;
    end else begin
      l_state       <= l_next;
      cnt           <= cnt_n;
      wr_en         <= wr_en_n;
      wr_addr       <= wr_addr_n;
      wr_data       <= wr_data_n;
      start_pooling <= start_pooling_n;
      load_done     <= load_done_n;
    end
  end

  always_comb begin
    l_next          = l_state;
    cnt_n           = cnt;
    wr_en_n         = 1'b0;
    wr_addr_n       = wr_addr;
    wr_data_n       = wr_data;
    start_pooling_n = 1'b0;
    load_done_n     = load_done;
    case (l_state)
      L_LOAD: begin
        if (byte_valid) begin
          wr_en_n   = 1'b1;
          wr_addr_n = cnt[ADDR_W-1:0];
          wr_data_n = shreg;
          cnt_n     = cnt + (ADDR_W + 1)'(1);
          if (cnt == LAST) l_next = L_START;
        end
      end
      L_START: begin
        start_pooling_n = 1'b1;
        l_next          = L_DONE;
      end
      // Image complete: later bytes are still received but never written.
      L_DONE: begin
        load_done_n = 1'b1;
      end
      default: l_next = L_LOAD;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// tb/tb_uart_rx_loader.sv - directed bench for uart_rx_loader (small image at 4 clk/bit, 256-byte image at 16 clk/bit)
module tb_uart_rx_loader;

  logic clk;
  logic reset_a, rx_a, wr_en_a, sp_a_sig, ld_a, busy_a_sig, fe_a;
  logic [11:0] wr_addr_a;
  logic [7:0]  wr_data_a;
  logic reset_b, rx_b, wr_en_b, sp_b_sig, ld_b, busy_b_sig, fe_b;
  logic [7:0]  wr_addr_b;
  logic [7:0]  wr_data_b;

  uart_rx_loader #(.CLKS_PER_BIT(4), .IMG_BYTES(4), .ADDR_W(12)) dut_a (
    .actual_clock(clk), .reset(reset_a), .rx(rx_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .start_pooling(sp_a_sig), .load_done(ld_a), .rx_busy(busy_a_sig), .frame_err(fe_a)
  );

  uart_rx_loader #(.CLKS_PER_BIT(16), .IMG_BYTES(256), .ADDR_W(8)) dut_b (
    .actual_clock(clk), .reset(reset_b), .rx(rx_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .start_pooling(sp_b_sig), .load_done(ld_b), .rx_busy(busy_b_sig), .frame_err(fe_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [11:0] wa_addr[$];
  logic [7:0]  wa_data[$];
  int sp_a = 0, busy_a = 0, last_wr_a = 0, sp_cyc_a = 0, ld_cyc_a = 0;
  logic ld_prev_a = 1'b0;

  logic [7:0] wb_addr[$];
  logic [7:0] wb_data[$];
  int sp_b = 0, last_wr_b = 0, sp_cyc_b = 0;

  logic [7:0] exp_b [256];

  always @(negedge clk) begin
    cyc++;
    if (reset_a) begin
      wa_addr.delete();
      wa_data.delete();
      sp_a = 0;
      busy_a = 0;
      ld_prev_a = 1'b0;
    end else begin
      if (wr_en_a) begin
        wa_addr.push_back(wr_addr_a);
        wa_data.push_back(wr_data_a);
        last_wr_a = cyc;
      end
      if (sp_a_sig) begin
        sp_a++;
        sp_cyc_a = cyc;
      end
      if (ld_a && !ld_prev_a) ld_cyc_a = cyc;
      ld_prev_a = ld_a;
      if (busy_a_sig) busy_a++;
    end
    if (reset_b) begin
      wb_addr.delete();
      wb_data.delete();
      sp_b = 0;
    end else begin
      if (wr_en_b) begin
        wb_addr.push_back(wr_addr_b);
        wb_data.push_back(wr_data_b);
        last_wr_b = cyc;
      end
      if (sp_b_sig) begin
        sp_b++;
        sp_cyc_b = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold_a(input logic v, input int n);
    rx_a = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop);
    hold_a(1'b0, 4);
    for (int i = 0; i < 8; i++) hold_a(d[i], 4);
    hold_a(stop, 4);
  endtask

  task automatic hold_b(input logic v, input int n);
    rx_b = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [7:0] d);
    hold_b(1'b0, 16);
    for (int i = 0; i < 8; i++) hold_b(d[i], 16);
    hold_b(1'b1, 16);
  endtask

  task automatic check_a_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, {31'd0, wr_en_a}, 32'd0);
    chk({tag, "_wr_addr"}, {20'd0, wr_addr_a}, 32'd0);
    chk({tag, "_wr_data"}, {24'd0, wr_data_a}, 32'd0);
    chk({tag, "_start_pooling"}, {31'd0, sp_a_sig}, 32'd0);
    chk({tag, "_load_done"}, {31'd0, ld_a}, 32'd0);
    chk({tag, "_rx_busy"}, {31'd0, busy_a_sig}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, fe_a}, 32'd0);
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_a_reset_outputs("reset");

    // Full image of four bytes
    reset_a = 1'b0;
    hold_a(1'b1, 4);
    send_a(8'hA5, 1'b1);
    send_a(8'h3C, 1'b1);
    send_a(8'hFF, 1'b1);
    send_a(8'h00, 1'b1);
    hold_a(1'b1, 12);
    chk("img_write_count", wa_addr.size(), 32'd4);
    if (wa_addr.size() == 4) begin
      chk("img_addr0", {20'd0, wa_addr[0]}, 32'd0);
      chk("img_data0", {24'd0, wa_data[0]}, 32'hA5);
      chk("img_addr1", {20'd0, wa_addr[1]}, 32'd1);
      chk("img_data1", {24'd0, wa_data[1]}, 32'h3C);
      chk("img_addr2", {20'd0, wa_addr[2]}, 32'd2);
      chk("img_data2", {24'd0, wa_data[2]}, 32'hFF);
      chk("img_addr3", {20'd0, wa_addr[3]}, 32'd3);
      chk("img_data3", {24'd0, wa_data[3]}, 32'h00);
    end
    chk("img_start_pulses", sp_a, 32'd1);
    chk("img_start_after_last_wr", sp_cyc_a - last_wr_a, 32'd1);
    chk("img_load_done_after_start", ld_cyc_a - sp_cyc_a, 32'd1);
    chk("img_load_done", {31'd0, ld_a}, 32'd1);
    chk("img_frame_err", {31'd0, fe_a}, 32'd0);

    // Extra byte after load_done is ignored
    send_a(8'h55, 1'b1);
    hold_a(1'b1, 12);
    chk("post_write_count", wa_addr.size(), 32'd4);
    chk("post_start_pulses", sp_a, 32'd1);
    chk("post_load_done", {31'd0, ld_a}, 32'd1);

    // Bad stop bit then a good byte
    reset_a = 1'b1;
    hold_a(1'b1, 3);
    reset_a = 1'b0;
    hold_a(1'b1, 4);
    send_a(8'h12, 1'b0);
    hold_a(1'b1, 8);
    send_a(8'h34, 1'b1);
    hold_a(1'b1, 8);
    chk("ferr_frame_err", {31'd0, fe_a}, 32'd1);
    chk("ferr_write_count", wa_addr.size(), 32'd1);
    if (wa_addr.size() >= 1) begin
      chk("ferr_addr0", {20'd0, wa_addr[0]}, 32'd0);
      chk("ferr_data0", {24'd0, wa_data[0]}, 32'h34);
    end

    // One-cycle low glitch (a quarter bit) is rejected
    reset_a = 1'b1;
    hold_a(1'b1, 3);
    reset_a = 1'b0;
    hold_a(1'b1, 4);
    hold_a(1'b0, 1);
    hold_a(1'b1, 16);
    chk("glitch_write_count", wa_addr.size(), 32'd0);
    chk("glitch_busy_cycles", busy_a, 32'd2);
    chk("glitch_rx_busy_end", {31'd0, busy_a_sig}, 32'd0);
    chk("glitch_frame_err", {31'd0, fe_a}, 32'd0);

    // Reset during the third byte, then a fresh image
    send_a(8'h11, 1'b1);
    send_a(8'h22, 1'b1);
    hold_a(1'b0, 4);
    hold_a(1'b1, 4);
    hold_a(1'b0, 4);
    hold_a(1'b1, 2);
    chk("abort_pre_writes", wa_addr.size(), 32'd2);
    chk("abort_pre_busy", {31'd0, busy_a_sig}, 32'd1);
    reset_a = 1'b1;
    rx_a = 1'b1;
    #1;
    check_a_reset_outputs("abort_in_reset");
    hold_a(1'b1, 3);
    check_a_reset_outputs("abort_held_reset");
    reset_a = 1'b0;
    hold_a(1'b1, 4);
    send_a(8'h44, 1'b1);
    send_a(8'h55, 1'b1);
    send_a(8'h66, 1'b1);
    send_a(8'h77, 1'b1);
    hold_a(1'b1, 12);
    chk("restart_write_count", wa_addr.size(), 32'd4);
    if (wa_addr.size() == 4) begin
      chk("restart_addr0", {20'd0, wa_addr[0]}, 32'd0);
      chk("restart_data0", {24'd0, wa_data[0]}, 32'h44);
      chk("restart_addr3", {20'd0, wa_addr[3]}, 32'd3);
      chk("restart_data3", {24'd0, wa_data[3]}, 32'h77);
    end
    chk("restart_start_pulses", sp_a, 32'd1);
    chk("restart_load_done", {31'd0, ld_a}, 32'd1);

    // Back-to-back frames, 256-byte image at 16 clocks per bit
    for (int i = 0; i < 256; i++) exp_b[i] = 8'($urandom_range(0, 255));
    reset_b = 1'b0;
    hold_b(1'b1, 4);
    for (int i = 0; i < 256; i++) send_b(exp_b[i]);
    hold_b(1'b1, 30);
    chk("b2b_write_count", wb_addr.size(), 32'd256);
    for (int i = 0; i < 256 && i < wb_addr.size(); i++) begin
      chk($sformatf("b2b_addr%0d", i), {24'd0, wb_addr[i]}, i);
      chk($sformatf("b2b_data%0d", i), {24'd0, wb_data[i]}, {24'd0, exp_b[i]});
    end
    chk("b2b_start_pulses", sp_b, 32'd1);
    chk("b2b_start_after_last_wr", sp_cyc_b - last_wr_b, 32'd1);
    chk("b2b_load_done", {31'd0, ld_b}, 32'd1);
    chk("b2b_frame_err", {31'd0, fe_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
